uart_program_loader: RTL and testbench
======================================

# uart_program_loader

Program loader placed directly downstream of the 32-bit UART word receiver. It consumes the received words (`instr`/`word_end` pair), interprets the first as a length header, writes the following payload words into instruction memory at sequential addresses, and verifies a trailing XOR checksum. The CPU core is held in reset until a load completes cleanly.

## Interface
- `ADDR_W`, 10: instruction memory word-address width; maximum payload is 2**ADDR_W words.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `word_in`  in  32  received word (receiver `instr`); stable while `word_valid` is high.
- `word_valid`  in  1  receiver `word_end`; a level lasting 1+ cycles marks one word.
- `reload`  in  1  synchronous one-cycle pulse: abort/restart the load sequence.
- `mem_we`  out  1  instruction memory write strobe, one-cycle pulse per word.
- `mem_addr`  out  ADDR_W  write word address.
- `mem_wdata`  out  32  write data.
- `cpu_reset`  out  1  active-high hold for the CPU core; released only in DONE.
- `load_done`  out  1  level, high in DONE.
- `load_error`  out  1  level, high in ERROR.

## Operation
- Word event: `word_valid` rising edge, from a registered copy of `word_valid`. Only the edge cycle samples `word_in`; a held level is one word.
- Registered previous-`word_valid` resets to 1. A level already high at reset release produces no event.
- WAIT_LEN: on event, latch N = `word_in`.
  - N == 0 or N > 2**ADDR_W -> ERROR.
  - Otherwise -> LOAD. Clear the address counter and the checksum accumulator.
- LOAD: on each event:
  - Write `word_in` at the current address.
  - XOR `word_in` into the 32-bit accumulator.
  - Increment the counter.
  - After the Nth word -> WAIT_CSUM.
- WAIT_CSUM: on event, compare `word_in` against the accumulator. Equal -> DONE; otherwise -> ERROR.
- DONE: `cpu_reset`=0, `load_done`=1. Further events are ignored.
- ERROR: `cpu_reset`=1, `load_error`=1. Further events are ignored.
- `reload` (any state) -> WAIT_LEN next cycle.
  - Clears `load_done`, `load_error`, counter and accumulator; sets `cpu_reset`=1.
  - `reload` coincident with an event: `reload` wins and the event is discarded.
- Address counter is ADDR_W+1 bits internally. `mem_addr` is its low ADDR_W bits. N == 2**ADDR_W writes addresses 0..2**ADDR_W-1 with no wrap.
- Reset mid-load: all state is lost and the sequence returns to WAIT_LEN. Partial memory contents are not cleared.

## Timing
- Reset values:
  - State WAIT_LEN.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_reset`=1, `load_done`=0, `load_error`=0.
- All outputs are registered.
- Write latency: event on cycle T -> `mem_we`=1 with the matching `mem_addr`/`mem_wdata` on cycle T+1. `mem_we` is low otherwise. `mem_addr`/`mem_wdata` hold their last values.
- Checksum event on T -> `load_done` or `load_error` high, and `cpu_reset` updated, on T+1.
- Bad header on T -> `load_error` high on T+1, with no write issued.
- `reload` on T -> outputs take their reset values on T+1 (except `mem_addr`/`mem_wdata`, which hold).
- Back-to-back events one cycle apart are supported, so one word per two cycles is sustained.

## Structure
- Shared package `loader_pkg`:
  - State enum (WAIT_LEN, LOAD, WAIT_CSUM, DONE, ERROR).
  - Default ADDR_W.
  - Width constant WORD_W=32.
- Sub-module `word_event_detect`: registers `word_valid` (reset value 1) and outputs the one-cycle rising-edge pulse. It is reusable by other UART consumers.
- The top level holds the FSM, counter, accumulator and output registers.

## Test plan
- Header 3, words 0x11111111, 0x22222222, 0x44444444, checksum 0x77777777 -> three writes to addresses 0,1,2 with that data. `load_done`=1 and `cpu_reset`=0 one cycle after the checksum event.
- Same payload with checksum 0x77777776 -> three writes issued, then `load_error`=1 and `cpu_reset` stays 1. A later event writes nothing.
- Header 0, then header 0x401 with ADDR_W=10 -> ERROR with no `mem_we` in either case.
- `word_valid` held high for 2 cycles per word (the receiver's behaviour), and one case held for 5 cycles -> exactly one write per word.
- `reload` asserted after 2 of 3 payload words, then a full 2-word load (0xA, 0xB, checksum 0x1) -> writes restart at address 0 and `load_done`=1. `reload` coincident with an event -> event ignored.
- `reset` asserted low mid-LOAD -> outputs return to reset values immediately (asynchronously). `word_valid` high at reset release -> no event.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: load-sequence states and widths.
package loader_pkg;

    localparam int LOADER_ADDR_W = 10;
    localparam int WORD_W        = 32;

    typedef enum logic [2:0] {
        WAIT_LEN,
        LOAD,
        WAIT_CSUM,
        DONE,
        ERROR
    } load_state_e;

endpackage

// File: rtl/uart_program_loader_if.sv
// Word stream from the UART receiver and the instruction-memory write port.
interface uart_program_loader_if #(
    parameter int ADDR_W = loader_pkg::LOADER_ADDR_W
);

    logic [loader_pkg::WORD_W-1:0] word_in;
    logic                          word_valid;
    logic                          mem_we;
    logic [ADDR_W-1:0]             mem_addr;
    logic [loader_pkg::WORD_W-1:0] mem_wdata;

    // The loader consumes words and drives the memory port.
    modport master (
        input  word_in,
        input  word_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output word_in,
        output word_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/word_event_detect.sv
// Turns the receiver's word_end level into a one-cycle rising-edge pulse.
module word_event_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_p0;

    // Resetting to 1 keeps a level already high at reset release from counting as a word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_p0 <= 1'b1;
        end else begin
            level_p0 <= level;
        end
    end

    assign pulse = level & ~level_p0;

endmodule

// File: rtl/uart_program_loader.sv
// Loads a length-prefixed, XOR-checksummed program into instruction memory and holds the CPU in reset until it succeeds.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = LOADER_ADDR_W
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_program_loader_if.master  bus,
    input  logic                   reload,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic                   load_error
);

    localparam logic [WORD_W-1:0] MAX_LEN = WORD_W'(2 ** ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    load_state_e         state_q, state_d;
    logic                word_evt;
    logic                hdr_ok;
    logic [ADDR_W:0]     cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W:0]     len_q, len_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                cpu_reset_d, load_done_d, load_error_d;

    word_event_detect u_word_event_detect (
        .clk   (clk),
        .reset (reset),
        .level (bus.word_valid),
        .pulse (word_evt)
    );

    assign hdr_ok  = (bus.word_in != '0) && (bus.word_in <= MAX_LEN);
    assign cnt_inc = cnt_q + CNT_ONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // reload takes priority over a coincident word event, which is dropped.
    always_comb begin
        state_d = state_q;
        if (reload) begin
            state_d = WAIT_LEN;
        end else if (word_evt) begin
            case (state_q)
                WAIT_LEN:  state_d = hdr_ok ? LOAD : ERROR;
                LOAD:      if (cnt_inc == len_q) state_d = WAIT_CSUM;
                WAIT_CSUM: state_d = (bus.word_in == acc_q) ? DONE : ERROR;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        len_d        = len_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_reset_d  = (state_d != DONE);
        load_done_d  = (state_d == DONE);
        load_error_d = (state_d == ERROR);
        if (reload) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (word_evt) begin
            case (state_q)
                WAIT_LEN: begin
                    if (hdr_ok) begin
                        len_d = bus.word_in[ADDR_W:0];
                        cnt_d = '0;
                        acc_d = '0;
                    end
                end
                LOAD: begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = bus.word_in;
                    cnt_d   = cnt_inc;
                    acc_d   = acc_q ^ bus.word_in;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_reset  <= cpu_reset_d;
            load_done  <= load_done_d;
            load_error <= load_error_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: good/bad loads, held word_valid, reload and reset cases.
module tb_uart_program_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reload = 1'b0;
    logic cpu_reset, load_done, load_error;

    int vectors = 0;
    int miscompares = 0;

    int          wr_n = 0;
    logic [9:0]  wr_addr [64];
    logic [31:0] wr_data [64];

    uart_program_loader_if #(.ADDR_W(10)) bus ();

    uart_program_loader #(.ADDR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .reload     (reload),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = bus.mem_addr;
                wr_data[wr_n] = bus.mem_wdata;
            end
            wr_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_word(input logic [31:0] w, input int hold);
        @(posedge clk);
        #1;
        bus.word_in    = w;
        bus.word_valid = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        bus.word_valid = 1'b0;
    endtask

    task automatic do_reload();
        @(posedge clk);
        #1 reload = 1'b1;
        @(posedge clk);
        #1 reload = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.word_in    = 32'h0;
        bus.word_valid = 1'b1;
        reset          = 1'b0;
        #12;
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got %0b want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 10'd0) begin miscompares++; $display("FAIL reset_mem_addr got %0h want 0", bus.mem_addr); end
        vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_mem_wdata got %0h want 0", bus.mem_wdata); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_reset got %0b want 1", cpu_reset); end
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_load_done got %0b want 0", load_done); end
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL reset_load_error got %0b want 0", load_error); end
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        // a spurious event here would read header 0 and raise load_error
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL held_at_release_error got %0b want 0", load_error); end
        vectors++; if (wr_n !== 0) begin miscompares++; $display("FAIL held_at_release_writes got %0d want 0", wr_n); end
        bus.word_valid = 1'b0;
    endtask

    task automatic test_good_load();
        int base;
        do_reload();
        base = wr_n;
        send_word(32'd3, 1);
        send_word(32'h11111111, 1);
        send_word(32'h22222222, 1);
        send_word(32'h44444444, 1);
        @(posedge clk);
        #1;
        bus.word_in    = 32'h77777777;
        bus.word_valid = 1'b1;
        @(negedge clk);
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL good_done_early got %0b want 0", load_done); end
        @(posedge clk);
        #1 bus.word_valid = 1'b0;
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL good_done got %0b want 1", load_done); end
        vectors++; if (cpu_reset !== 1'b0) begin miscompares++; $display("FAIL good_cpu_reset got %0b want 0", cpu_reset); end
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL good_error got %0b want 0", load_error); end
        settle();
        vectors++; if (wr_n - base !== 3) begin miscompares++; $display("FAIL good_write_count got %0d want 3", wr_n - base); end
        vectors++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h11111111) begin miscompares++; $display("FAIL good_write0 got %0h/%0h want 0/11111111", wr_addr[base], wr_data[base]); end
        vectors++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h22222222) begin miscompares++; $display("FAIL good_write1 got %0h/%0h want 1/22222222", wr_addr[base+1], wr_data[base+1]); end
        vectors++; if (wr_addr[base+2] !== 10'd2 || wr_data[base+2] !== 32'h44444444) begin miscompares++; $display("FAIL good_write2 got %0h/%0h want 2/44444444", wr_addr[base+2], wr_data[base+2]); end
    endtask

    task automatic test_bad_checksum();
        int base;
        do_reload();
        vectors++; if (load_done !== 1'b0 || cpu_reset !== 1'b1) begin miscompares++; $display("FAIL reload_from_done got done=%0b cpu_reset=%0b want 0/1", load_done, cpu_reset); end
        base = wr_n;
        send_word(32'd3, 1);
        send_word(32'h11111111, 1);
        send_word(32'h22222222, 1);
        send_word(32'h44444444, 1);
        send_word(32'h77777776, 1);
        settle();
        vectors++; if (wr_n - base !== 3) begin miscompares++; $display("FAIL badcs_write_count got %0d want 3", wr_n - base); end
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL badcs_error got %0b want 1", load_error); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL badcs_cpu_reset got %0b want 1", cpu_reset); end
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL badcs_done got %0b want 0", load_done); end
        send_word(32'h12345678, 1);
        settle();
        vectors++; if (wr_n - base !== 3) begin miscompares++; $display("FAIL badcs_ignored_event got %0d writes want 3", wr_n - base); end
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL badcs_error_sticky got %0b want 1", load_error); end
    endtask

    task automatic test_bad_header();
        int base;
        do_reload();
        vectors++; if (load_error !== 1'b0) begin miscompares++; $display("FAIL reload_clears_error got %0b want 0", load_error); end
        base = wr_n;
        send_word(32'd0, 1);
        settle();
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL hdr0_error got %0b want 1", load_error); end
        vectors++; if (wr_n - base !== 0) begin miscompares++; $display("FAIL hdr0_writes got %0d want 0", wr_n - base); end
        do_reload();
        send_word(32'h401, 1);
        settle();
        vectors++; if (load_error !== 1'b1) begin miscompares++; $display("FAIL hdr401_error got %0b want 1", load_error); end
        vectors++; if (wr_n - base !== 0) begin miscompares++; $display("FAIL hdr401_writes got %0d want 0", wr_n - base); end
        vectors++; if (cpu_reset !== 1'b1) begin miscompares++; $display("FAIL hdr401_cpu_reset got %0b want 1", cpu_reset); end
    endtask

    task automatic test_held_valid();
        int base;
        do_reload();
        base = wr_n;
        send_word(32'd2, 2);
        send_word(32'hA5A50001, 2);
        send_word(32'h000000FF, 5);
        send_word(32'hA5A500FE, 2);
        settle();
        vectors++; if (wr_n - base !== 2) begin miscompares++; $display("FAIL held_write_count got %0d want 2", wr_n - base); end
        vectors++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'hA5A50001) begin miscompares++; $display("FAIL held_write0 got %0h/%0h want 0/a5a50001", wr_addr[base], wr_data[base]); end
        vectors++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'h000000FF) begin miscompares++; $display("FAIL held_write1 got %0h/%0h want 1/ff", wr_addr[base+1], wr_data[base+1]); end
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL held_done got %0b want 1", load_done); end
    endtask

    task automatic test_reload_midload();
        int base;
        do_reload();
        base = wr_n;
        send_word(32'd3, 1);
        send_word(32'h1, 1);
        send_word(32'h2, 1);
        settle();
        vectors++; if (wr_n - base !== 2) begin miscompares++; $display("FAIL partial_write_count got %0d want 2", wr_n - base); end
        do_reload();
        vectors++; if (cpu_reset !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin miscompares++; $display("FAIL midload_reload_outputs got %0b%0b%0b want 100", cpu_reset, load_done, load_error); end
        base = wr_n;
        send_word(32'd2, 1);
        send_word(32'hA, 1);
        send_word(32'hB, 1);
        send_word(32'h1, 1);
        settle();
        vectors++; if (wr_n - base !== 2) begin miscompares++; $display("FAIL restart_write_count got %0d want 2", wr_n - base); end
        vectors++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'hA) begin miscompares++; $display("FAIL restart_write0 got %0h/%0h want 0/a", wr_addr[base], wr_data[base]); end
        vectors++; if (wr_addr[base+1] !== 10'd1 || wr_data[base+1] !== 32'hB) begin miscompares++; $display("FAIL restart_write1 got %0h/%0h want 1/b", wr_addr[base+1], wr_data[base+1]); end
        vectors++; if (load_done !== 1'b1 || cpu_reset !== 1'b0) begin miscompares++; $display("FAIL restart_done got done=%0b cpu_reset=%0b want 1/0", load_done, cpu_reset); end
    endtask

    task automatic test_reload_coincident();
        int base;
        do_reload();
        base = wr_n;
        send_word(32'd2, 1);
        @(posedge clk);
        #1;
        bus.word_in    = 32'hC;
        bus.word_valid = 1'b1;
        reload         = 1'b1;
        @(posedge clk);
        #1;
        reload         = 1'b0;
        bus.word_valid = 1'b0;
        settle();
        vectors++; if (wr_n - base !== 0) begin miscompares++; $display("FAIL coincident_write got %0d writes want 0", wr_n - base); end
        send_word(32'd1, 1);
        send_word(32'h5, 1);
        send_word(32'h5, 1);
        settle();
        vectors++; if (wr_n - base !== 1) begin miscompares++; $display("FAIL coincident_reload_count got %0d want 1", wr_n - base); end
        vectors++; if (wr_addr[base] !== 10'd0 || wr_data[base] !== 32'h5) begin miscompares++; $display("FAIL coincident_write0 got %0h/%0h want 0/5", wr_addr[base], wr_data[base]); end
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL coincident_done got %0b want 1", load_done); end
    endtask

    task automatic test_async_reset();
        int base;
        do_reload();
        send_word(32'd3, 1);
        send_word(32'h11, 1);
        @(posedge clk);
        #1;
        bus.word_in    = 32'h22;
        bus.word_valid = 1'b1;
        @(posedge clk);
        #2;
        vectors++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 10'd1) begin miscompares++; $display("FAIL pre_reset_write got we=%0b addr=%0h want 1/1", bus.mem_we, bus.mem_addr); end
        reset = 1'b0;
        #1;
        vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL async_mem_we got %0b want 0", bus.mem_we); end
        vectors++; if (bus.mem_addr !== 10'd0 || bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL async_addr_data got %0h/%0h want 0/0", bus.mem_addr, bus.mem_wdata); end
        vectors++; if (cpu_reset !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin miscompares++; $display("FAIL async_status got %0b%0b%0b want 100", cpu_reset, load_done, load_error); end
        bus.word_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        base = wr_n;
        send_word(32'd1, 1);
        send_word(32'h7, 1);
        send_word(32'h7, 1);
        settle();
        vectors++; if (wr_n - base !== 1 || wr_addr[base] !== 10'd0) begin miscompares++; $display("FAIL post_reset_load got %0d writes addr %0h want 1/0", wr_n - base, wr_addr[base]); end
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL post_reset_done got %0b want 1", load_done); end
    endtask

    initial begin
        bus.word_in    = 32'h0;
        bus.word_valid = 1'b0;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_bad_header();
        test_held_valid();
        test_reload_midload();
        test_reload_coincident();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
